// File: rtl/multiplicador_sequencial_8bits_pkg.sv
// multiplicador_sequencial_8bits_pkg: state encodings and sizing shared by the sequential multiplier
package multiplicador_sequencial_8bits_pkg;
  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    FIM     = 2'b10
  } estado_t;
  localparam int LARGURA = 8;
  localparam int N_ITER  = 8;
endpackage

// File: rtl/multiplicador_sequencial_8bits_somador.sv
// somador_8bits: 8-bit ripple-carry adder with carry-in and carry-out
module somador_8bits
  import multiplicador_sequencial_8bits_pkg::*;
(
  input  logic [LARGURA-1:0] i_a,
  input  logic [LARGURA-1:0] i_b,
  input  logic               i_cin,
  output logic [LARGURA-1:0] o_soma,
  output logic               o_cout
);
  logic [LARGURA:0] w_c;
  assign w_c[0] = i_cin;
  for (genvar i = 0; i < LARGURA; i++) begin : g_fa
    assign o_soma[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
  assign o_cout = w_c[LARGURA];
endmodule

// File: rtl/multiplicador_sequencial_8bits.sv
// multiplicador_sequencial_8bits: shift-and-add 8x8 multiplier, low byte plus overflow flag
// MULT_ENCERRAMENTO_ANTECIPADO_EN: finish as soon as the remaining multiplier bits are all zero
module multiplicador_sequencial_8bits #(
  parameter int LARGURA = multiplicador_sequencial_8bits_pkg::LARGURA
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Iniciar,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic [LARGURA-1:0] Produto,
  output logic               Overflow,
  output logic               Ocupado,
  output logic               Pronto
);
  import multiplicador_sequencial_8bits_pkg::*;
  estado_t r_estado, w_prox;
  logic [2*LARGURA-1:0] r_mcando, r_acc, w_parcela, w_soma;
  logic [LARGURA-1:0] r_mdor, w_mdor_prox;
  logic [3:0] r_cont;
  logic w_c_baixo, w_c_alto, w_ultimo;
  assign w_parcela   = r_mdor[0] ? r_mcando : '0;
  assign w_mdor_prox = r_mdor >> 1;
  // Two byte adders chained through the carry form the 16-bit accumulate
  somador_8bits u_baixo (
    .i_a    (r_acc[LARGURA-1:0]),
    .i_b    (w_parcela[LARGURA-1:0]),
    .i_cin  (1'b0),
    .o_soma (w_soma[LARGURA-1:0]),
    .o_cout (w_c_baixo)
  );
  somador_8bits u_alto (
    .i_a    (r_acc[2*LARGURA-1:LARGURA]),
    .i_b    (w_parcela[2*LARGURA-1:LARGURA]),
    .i_cin  (w_c_baixo),
    .o_soma (w_soma[2*LARGURA-1:LARGURA]),
    .o_cout (w_c_alto)
  );
`ifdef MULT_ENCERRAMENTO_ANTECIPADO_EN
  assign w_ultimo = (r_cont == 4'(N_ITER - 1)) || (w_mdor_prox == '0);
`else
  assign w_ultimo = r_cont == 4'(N_ITER - 1);
`endif
  always_ff @(posedge Clock) begin
    if (Reset) r_estado <= OCIOSO;
    else r_estado <= w_prox;
  end
  always_comb begin
    w_prox  = r_estado == OCIOSO  ? (Iniciar ? CALCULA : OCIOSO) :
              r_estado == CALCULA ? (w_ultimo ? FIM : CALCULA) : OCIOSO;
    Ocupado = r_estado == CALCULA;
    Pronto  = r_estado == FIM;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_mcando <= '0;
      r_mdor   <= '0;
      r_acc    <= '0;
      r_cont   <= '0;
      Produto  <= '0;
      Overflow <= 1'b0;
    end else if (r_estado == OCIOSO && Iniciar) begin
      r_mcando <= {{LARGURA{1'b0}}, A};
      r_mdor   <= B;
      r_acc    <= '0;
      r_cont   <= '0;
    end else if (r_estado == CALCULA) begin
      r_acc    <= w_soma;
      r_mdor   <= w_mdor_prox;
      r_mcando <= r_mcando << 1;
      r_cont   <= r_cont + 4'd1;
      // The carry out of the high byte never fires; folding it in keeps the flag complete
      if (w_ultimo) begin
        Produto  <= w_soma[LARGURA-1:0];
        Overflow <= |{w_c_alto, w_soma[2*LARGURA-1:LARGURA]};
      end
    end
  end
endmodule

// File: tb/tb_multiplicador_sequencial_8bits.sv
// tb_multiplicador_sequencial_8bits: scoreboard bench for the sequential multiplier
module tb_multiplicador_sequencial_8bits;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Iniciar = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic [7:0] Produto;
  logic Overflow, Ocupado, Pronto;
  int n_total = 0;
  int n_ok = 0;
  typedef struct {
    logic [7:0] prod;
    logic       ovf;
    int         lat;
  } esp_t;
  esp_t sb[$];

  multiplicador_sequencial_8bits #(.LARGURA(8)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Iniciar  (Iniciar),
    .A        (A),
    .B        (B),
    .Produto  (Produto),
    .Overflow (Overflow),
    .Ocupado  (Ocupado),
    .Pronto   (Pronto)
  );

  always #5 Clock = ~Clock;

  function automatic int lat_esperada(input logic [7:0] b);
    int l;
`ifdef MULT_ENCERRAMENTO_ANTECIPADO_EN
    l = 1;
    for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
`else
    l = 8;
`endif
    return l;
  endfunction

  function automatic esp_t modelo(input logic [7:0] a, input logic [7:0] b);
    esp_t e;
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    e.prod = p[7:0];
    e.ovf = |p[15:8];
    e.lat = lat_esperada(b);
    return e;
  endfunction

  task automatic executar(input logic [7:0] a, input logic [7:0] b, input int pulso,
                          output logic [7:0] prod, output logic ovf, output int lat,
                          output bit ok, output logic ocup);
    sb.push_back(modelo(a, b));
    @(negedge Clock);
    A = a;
    B = b;
    Iniciar = 1'b1;
    @(posedge Clock);
    lat = 0;
    ok = 1'b0;
    ocup = 1'b0;
    prod = '0;
    ovf = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge Clock);
      if (i == 0) ocup = Ocupado;
      Iniciar = (lat == pulso - 1);
      A = Iniciar ? 8'd3 : 8'($urandom);
      B = Iniciar ? 8'd3 : 8'($urandom);
      if (Pronto) begin
        ok = 1'b1;
        prod = Produto;
        ovf = Overflow;
      end else begin
        @(posedge Clock);
        lat++;
      end
    end
    Iniciar = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Iniciar = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    n_total++; if (Produto !== 8'd0) $display("FAIL reset_produto: got %0d want 0", Produto); else n_ok++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", Overflow); else n_ok++;
    n_total++; if (Ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b want 0", Ocupado); else n_ok++;
    n_total++; if (Pronto !== 1'b0) $display("FAIL reset_pronto: got %b want 0", Pronto); else n_ok++;
    Iniciar = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic test_casos();
    logic [7:0] va[7], vb[7], a, b, prod;
    logic ovf, ocup;
    int lat;
    bit ok;
    esp_t e;
    va = '{8'd12, 8'd16, 8'd255, 8'd255, 8'd200, 8'd0, 8'd1};
    vb = '{8'd10, 8'd16, 8'd255, 8'd1, 8'd0, 8'd255, 8'd128};
    for (int i = 0; i < 11; i++) begin
      a = i < 7 ? va[i] : 8'($urandom);
      b = i < 7 ? vb[i] : 8'($urandom);
      executar(a, b, 0, prod, ovf, lat, ok, ocup);
      e = sb.pop_front();
      n_total++; if (!ok) $display("FAIL caso%0d_timeout: no Pronto for %0d*%0d", i, a, b); else n_ok++;
      n_total++; if (prod !== e.prod) $display("FAIL caso%0d_produto: %0d*%0d got %0d want %0d", i, a, b, prod, e.prod); else n_ok++;
      n_total++; if (ovf !== e.ovf) $display("FAIL caso%0d_overflow: %0d*%0d got %b want %b", i, a, b, ovf, e.ovf); else n_ok++;
      n_total++; if (lat !== e.lat) $display("FAIL caso%0d_latencia: %0d*%0d got %0d want %0d", i, a, b, lat, e.lat); else n_ok++;
      n_total++; if (ocup !== 1'b1) $display("FAIL caso%0d_ocupado: got %b want 1", i, ocup); else n_ok++;
      @(negedge Clock);
      n_total++; if (Pronto !== 1'b0) $display("FAIL caso%0d_pulso: Pronto got %b want 0", i, Pronto); else n_ok++;
      n_total++; if (Produto !== e.prod) $display("FAIL caso%0d_retem: Produto got %0d want %0d", i, Produto, e.prod); else n_ok++;
    end
  endtask

  task automatic test_iniciar_ignorado();
    logic [7:0] prod;
    logic ovf, ocup;
    int lat;
    bit ok;
    esp_t e;
    executar(8'd12, 8'd10, 3, prod, ovf, lat, ok, ocup);
    e = sb.pop_front();
    n_total++; if (!ok) $display("FAIL ignorado_timeout: no Pronto"); else n_ok++;
    n_total++; if (prod !== e.prod) $display("FAIL ignorado_produto: got %0d want %0d", prod, e.prod); else n_ok++;
    n_total++; if (lat !== e.lat) $display("FAIL ignorado_latencia: got %0d want %0d", lat, e.lat); else n_ok++;
    @(negedge Clock);
    n_total++; if (Ocupado !== 1'b0) $display("FAIL ignorado_ocioso: Ocupado got %b want 0", Ocupado); else n_ok++;
  endtask

  task automatic test_reset_abortar();
    int pulsos;
    logic [7:0] prod;
    logic ovf, ocup;
    int lat;
    bit ok;
    esp_t e;
    @(negedge Clock);
    A = 8'd5;
    B = 8'd7;
    Iniciar = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Iniciar = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    n_total++; if (Ocupado !== 1'b1) $display("FAIL abortar_antes: Ocupado got %b want 1", Ocupado); else n_ok++;
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    n_total++; if (Ocupado !== 1'b0) $display("FAIL abortar_ocupado: got %b want 0", Ocupado); else n_ok++;
    n_total++; if (Produto !== 8'd0) $display("FAIL abortar_produto: got %0d want 0", Produto); else n_ok++;
    n_total++; if (Overflow !== 1'b0) $display("FAIL abortar_overflow: got %b want 0", Overflow); else n_ok++;
    pulsos = 0;
    repeat (12) begin
      @(negedge Clock);
      if (Pronto) pulsos++;
    end
    n_total++; if (pulsos !== 0) $display("FAIL abortar_pronto: got %0d pulses want 0", pulsos); else n_ok++;
    executar(8'd9, 8'd9, 0, prod, ovf, lat, ok, ocup);
    e = sb.pop_front();
    n_total++; if (!ok || prod !== e.prod) $display("FAIL abortar_retoma: got %0d want %0d (ok=%b)", prod, e.prod, ok); else n_ok++;
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    esp_t e;
    t1 = -1;
    t2 = -1;
    sb.push_back(modelo(8'd7, 8'd255));
    sb.push_back(modelo(8'd7, 8'd255));
    @(negedge Clock);
    A = 8'd7;
    B = 8'd255;
    Iniciar = 1'b1;
    for (int n = 0; n < 40 && t2 < 0; n++) begin
      @(negedge Clock);
      if (Pronto) begin
        e = sb.pop_front();
        n_total++; if (Produto !== e.prod || Overflow !== e.ovf) $display("FAIL b2b_resultado: got %0d/%b want %0d/%b", Produto, Overflow, e.prod, e.ovf); else n_ok++;
        if (t1 < 0) t1 = n;
        else begin
          t2 = n;
          Iniciar = 1'b0;
        end
      end
    end
    Iniciar = 1'b0;
    n_total++; if (t2 < 0) $display("FAIL b2b_timeout: second Pronto missing (t1=%0d)", t1); else n_ok++;
    n_total++; if (t2 - t1 !== 10) $display("FAIL b2b_intervalo: got %0d want 10", t2 - t1); else n_ok++;
    repeat (3) @(negedge Clock);
    n_total++; if (Ocupado !== 1'b0) $display("FAIL b2b_parado: Ocupado got %b want 0", Ocupado); else n_ok++;
  endtask

  initial begin
    test_reset();
    test_casos();
    test_iniciar_ignorado();
    test_reset_abortar();
    test_back_to_back();
    n_total++; if (sb.size() !== 0) $display("FAIL scoreboard_vazio: %0d left want 0", sb.size()); else n_ok++;
    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end
endmodule
